placar_multi: RTL and testbench
===============================

PLACAR_MULTI -- requirements
Module: placar_multi

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of players (2..4).
REQ-002 SHALL have parameter WIN_POINTS, default 7, points needed to win (1..15).
REQ-003 SHALL have parameter BLINK_DIV, default 25_000_000, clock cycles per blink half-period (>=2).
REQ-004 SHALL have port clock  input  1  single system clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port vic  input  N_PLAYERS  per-player round-won level; bit i = player i.
REQ-007 SHALL have port new_game  input  1  synchronous match restart, level-sampled.
REQ-008 SHALL have port LED  output  N_PLAYERS*WIN_POINTS  thermometer score display; segment i = bits [i*WIN_POINTS +: WIN_POINTS].
REQ-009 SHALL have port score  output  N_PLAYERS*4  per-player score, player i in bits [4i +: 4].
REQ-010 SHALL have port game_over  output  1  high while match finished.
REQ-011 SHALL have port winner  output  N_PLAYERS  one-hot/multi-hot mask of players at WIN_POINTS.
REQ-012 SHALL have port tie  output  1  high when more than one winner bit set.
REQ-013 SHALL have port point  output  N_PLAYERS  one-cycle pulse per accepted point.

Function
REQ-014 SHALL register vic every cycle, regardless of state; accepted event i = vic[i] & ~vic_prev[i] (rising edge, 1-cycle latency from input change).
REQ-015 SHALL implement FSM states PLAYING and OVER; reset enters PLAYING.
REQ-016 In PLAYING, each edge on player i with score_i < WIN_POINTS SHALL increment score_i by 1 and set LED bit i*WIN_POINTS+score_i on the next clock edge.
REQ-017 SHALL pulse point[i] in the same cycle the score_i register updates.
REQ-018 Simultaneous edges from several players SHALL all be accepted in the same cycle.
REQ-019 When any score reaches WIN_POINTS, FSM SHALL move to OVER on that same edge; winner = all players whose score equals WIN_POINTS; tie = popcount(winner) > 1.
REQ-020 In OVER, edges SHALL be ignored: no score, LED, or point change.
REQ-021 Score SHALL saturate at WIN_POINTS; never wrap.
REQ-022 new_game high SHALL, on the next edge, clear score, LED, winner, tie, point, blink state, enter PLAYING; valid from either state.
REQ-023 new_game SHALL take priority over a simultaneous edge; that edge is discarded (vic_prev still updates).
REQ-024 In OVER, a blink counter SHALL count 0..BLINK_DIV-1 and toggle a phase bit on wrap; phase starts at 1 (on) on entering OVER.
REQ-025 LED SHALL show stored bits ANDed with ~(winner-segment mask) when phase = 0; non-winner segments always steady.
REQ-026 In PLAYING, blink counter SHALL be held at 0 and LED SHALL equal stored bits.
REQ-027 game_over SHALL equal (state == OVER).
REQ-028 All outputs SHALL be registered or pure decodes of registered state; no combinational path input->output.

Reset
REQ-029 reset SHALL asynchronously clear score, stored LED bits, vic_prev, winner, tie, point, blink counter, phase, state = PLAYING.
REQ-030 Reset asserted mid-match or mid-blink SHALL produce LED = 0, game_over = 0 immediately, without waiting for clock.
REQ-031 A vic level held high across reset release SHALL NOT score (vic_prev cleared, so edge requires prior low... first cycle: vic_prev=0 means held-high scores once) -- decided: vic_prev SHALL be loaded with vic on the first clock after reset release without accepting an edge.

Structure
REQ-032 Package placar_pkg SHALL hold state enum (PLAYING, OVER) and the 4-bit score type.
REQ-033 Rising-edge detection SHALL be one sub-module edge_detector_s, instanced N_PLAYERS times via generate, with the first-cycle suppression of REQ-031 via a shared armed flag.
REQ-034 Blink divider SHALL be inline; counter width = $clog2(BLINK_DIV).

Verification
REQ-035 N=2,W=7: 7 single-cycle pulses on vic[0] -> score0=7, LED[6:0]=7'h7F, game_over=1, winner=2'b01, tie=0.
REQ-036 Both at 6, vic=2'b11 pulsed together -> both score 7, winner=2'b11, tie=1, one OVER transition.
REQ-037 vic[1] held high 20 cycles -> score1=1, exactly one point[1] pulse.
REQ-038 In OVER, pulse vic[1] -> no change; new_game + vic[0] same cycle -> all scores 0, PLAYING, no point.
REQ-039 BLINK_DIV=4, player 0 wins -> segment 0 on 4 cycles, off 4, repeating; segment 1 steady.
REQ-040 Reset asserted between clock edges at score 3 -> LED=0 asynchronously; vic held high through release -> no point.

Source files
------------

// File: rtl/placar_pkg.sv
// Shared types for the multi-player scoreboard: FSM state and score type.
package placar_pkg;

    typedef enum logic {
        PLAYING = 1'b0,
        OVER    = 1'b1
    } state_e;

    typedef logic [3:0] score_t;

    // True when more than one bit of a (zero-padded) winner mask is set.
    function automatic logic more_than_one(input logic [3:0] mask);
        return (mask & (mask - 4'd1)) != 4'd0;
    endfunction

endpackage

// File: rtl/placar_multi_if.sv
// Player-facing bus of the scoreboard: round-won inputs, restart, and display/status outputs.
interface placar_multi_if #(
    parameter int N_PLAYERS  = 2,
    parameter int WIN_POINTS = 7
);
    logic [N_PLAYERS-1:0]            vic;
    logic                            new_game;
    logic [N_PLAYERS*WIN_POINTS-1:0] LED;
    logic [N_PLAYERS*4-1:0]          score;
    logic                            game_over;
    logic [N_PLAYERS-1:0]            winner;
    logic                            tie;
    logic [N_PLAYERS-1:0]            point;

    modport master (
        output vic, new_game,
        input  LED, score, game_over, winner, tie, point
    );

    modport slave (
        input  vic, new_game,
        output LED, score, game_over, winner, tie, point
    );
endinterface

// File: rtl/edge_detector_s.sv
// Rising-edge detector for one player's round-won level. The shared armed flag
// suppresses the very first cycle after reset so a level held through reset
// release only primes the history register.
module edge_detector_s (
    input  logic clock,
    input  logic reset,
    input  logic armed,
    input  logic d,
    output logic rise
);
    logic prev_q;
    logic prev_d;

    // History always follows the input, whatever the match state.
    always_comb begin
        prev_d = d;
    end

    // Previous-level register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = armed & d & ~prev_q;
endmodule

// File: rtl/placar_multi.sv
// Multi-player point scoreboard with thermometer LED display, win/tie detection
// and blinking of the winner segments once the match is over.
module placar_multi
    import placar_pkg::*;
#(
    parameter int N_PLAYERS  = 2,
    parameter int WIN_POINTS = 7,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic          clock,
    input  logic          reset,
    placar_multi_if.slave bus
);
    localparam int            NW        = N_PLAYERS * WIN_POINTS;
    localparam int            CW        = $clog2(BLINK_DIV);
    localparam score_t        WIN_SCORE = score_t'(WIN_POINTS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BLINK_DIV - 1);
    localparam logic [NW-1:0] LED_ONE   = NW'(1);
    localparam logic [NW-1:0] SEG_ONES  = NW'((1 << WIN_POINTS) - 1);

    state_e                       state_q, state_d;
    score_t [N_PLAYERS-1:0]       score_q, score_d;
    logic   [NW-1:0]              led_q, led_d;
    logic   [N_PLAYERS-1:0]       winner_q, winner_d;
    logic                         tie_q, tie_d;
    logic   [N_PLAYERS-1:0]       point_q, point_d;
    logic   [CW-1:0]              cnt_q, cnt_d;
    logic                         phase_q, phase_d;
    logic                         armed_q, armed_d;

    logic   [N_PLAYERS-1:0]       rise;
    logic   [N_PLAYERS-1:0]       win_now;
    logic   [3:0]                 win_pad;
    logic   [NW-1:0]              blink_mask;

    for (genvar g = 0; g < N_PLAYERS; g++) begin : g_edge
        edge_detector_s u_edge (
            .clock (clock),
            .reset (reset),
            .armed (armed_q),
            .d     (bus.vic[g]),
            .rise  (rise[g])
        );
    end

    // Next-state logic: restart has priority, then scoring while playing, then blink timing when over.
    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        led_d    = led_q;
        winner_d = winner_q;
        tie_d    = tie_q;
        point_d  = '0;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        armed_d  = 1'b1;
        win_now  = '0;
        win_pad  = '0;

        if (bus.new_game) begin
            state_d  = PLAYING;
            score_d  = '0;
            led_d    = '0;
            winner_d = '0;
            tie_d    = 1'b0;
            cnt_d    = '0;
            phase_d  = 1'b0;
        end else if (state_q == PLAYING) begin
            cnt_d = '0;
            for (int i = 0; i < N_PLAYERS; i++) begin
                if (rise[i] && (score_q[i] < WIN_SCORE)) begin
                    score_d[i] = score_q[i] + score_t'(1);
                    led_d      = led_d | (LED_ONE << (i * WIN_POINTS + int'(score_q[i])));
                    point_d[i] = 1'b1;
                end
                win_now[i] = (score_d[i] == WIN_SCORE);
            end
            if (|win_now) begin
                state_d                 = OVER;
                winner_d                = win_now;
                win_pad[N_PLAYERS-1:0]  = win_now;
                tie_d                   = more_than_one(win_pad);
                cnt_d                   = '0;
                phase_d                 = 1'b1;
            end
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers, all cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= PLAYING;
            score_q  <= '0;
            led_q    <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
            point_q  <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            led_q    <= led_d;
            winner_q <= winner_d;
            tie_q    <= tie_d;
            point_q  <= point_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            armed_q  <= armed_d;
        end
    end

    // Mask covering every segment that belongs to a winner.
    always_comb begin
        blink_mask = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (winner_q[i]) begin
                blink_mask = blink_mask | (SEG_ONES << (i * WIN_POINTS));
            end
        end
    end

    assign bus.LED       = ((state_q == OVER) && !phase_q) ? (led_q & ~blink_mask) : led_q;
    assign bus.score     = score_q;
    assign bus.game_over = (state_q == OVER);
    assign bus.winner    = winner_q;
    assign bus.tie       = tie_q;
    assign bus.point     = point_q;
endmodule

// File: tb/tb_placar_multi.sv
// Scoreboard-driven bench for placar_multi: a behavioural reference model
// predicts the outputs after every clock and queues them for comparison.
module tb_placar_multi;
    localparam int NP = 2;
    localparam int WP = 7;
    localparam int BD = 4;
    localparam int LW = NP * WP;

    typedef struct {
        logic [NP*4-1:0] score;
        logic [LW-1:0]   led;
        logic [NP-1:0]   point;
        logic            game_over;
        logic [NP-1:0]   winner;
        logic            tie;
    } exp_t;

    logic clock;
    logic reset;

    int error_count = 0;
    int check_count = 0;

    exp_t sb_q[$];

    // Reference model state
    int          m_score[NP];
    logic [NP-1:0] m_prev;
    logic [NP-1:0] m_point;
    logic [NP-1:0] m_winner;
    bit          m_armed;
    bit          m_over;
    bit          m_tie;
    int          m_over_cycles;

    placar_multi_if #(.N_PLAYERS(NP), .WIN_POINTS(WP)) bus ();

    placar_multi #(
        .N_PLAYERS  (NP),
        .WIN_POINTS (WP),
        .BLINK_DIV  (BD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NP; i++) m_score[i] = 0;
        m_prev        = '0;
        m_point       = '0;
        m_winner      = '0;
        m_armed       = 1'b0;
        m_over        = 1'b0;
        m_tie         = 1'b0;
        m_over_cycles = 0;
    endtask

    task automatic modelStep(input logic [NP-1:0] v, input logic ng);
        logic [NP-1:0] ev;
        int wins;
        ev = m_armed ? (v & ~m_prev) : '0;
        m_point = '0;
        if (ng) begin
            for (int i = 0; i < NP; i++) m_score[i] = 0;
            m_over        = 1'b0;
            m_winner      = '0;
            m_tie         = 1'b0;
            m_over_cycles = 0;
        end else if (!m_over) begin
            for (int i = 0; i < NP; i++) begin
                if (ev[i] && m_score[i] < WP) begin
                    m_score[i]++;
                    m_point[i] = 1'b1;
                end
            end
            wins = 0;
            for (int i = 0; i < NP; i++) begin
                if (m_score[i] == WP) begin
                    m_winner[i] = 1'b1;
                    wins++;
                end
            end
            if (wins > 0) begin
                m_over        = 1'b1;
                m_tie         = (wins > 1);
                m_over_cycles = 0;
            end
        end else begin
            m_over_cycles++;
        end
        m_prev  = v;
        m_armed = 1'b1;
    endtask

    function automatic exp_t expectedNow();
        exp_t e;
        logic [WP-1:0] seg;
        bit blink_off;
        blink_off = m_over && (((m_over_cycles / BD) % 2) == 1);
        e.score = '0;
        e.led   = '0;
        for (int i = 0; i < NP; i++) begin
            e.score = e.score | ((NP*4)'(4'(m_score[i])) << (4 * i));
            seg = '0;
            for (int b = 0; b < WP; b++) begin
                if (b < m_score[i]) seg = seg | (WP'(1) << b);
            end
            if (blink_off && m_winner[i]) seg = '0;
            e.led = e.led | (LW'(seg) << (i * WP));
        end
        e.point     = m_point;
        e.game_over = m_over;
        e.winner    = m_winner;
        e.tie       = m_tie;
        return e;
    endfunction

    task automatic compareNext();
        exp_t e;
        if (sb_q.size() == 0) begin
            checkOutput("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            checkOutput("score",     bus.score,     e.score);
            checkOutput("led",       bus.LED,       e.led);
            checkOutput("point",     bus.point,     e.point);
            checkOutput("game_over", bus.game_over, e.game_over);
            checkOutput("winner",    bus.winner,    e.winner);
            checkOutput("tie",       bus.tie,       e.tie);
        end
    endtask

    // One clock of stimulus: drive at the falling edge, predict, compare just after the rising edge.
    task automatic applyStimulus(input logic [NP-1:0] v, input logic ng);
        @(negedge clock);
        bus.vic      = v;
        bus.new_game = ng;
        modelStep(v, ng);
        sb_q.push_back(expectedNow());
        @(posedge clock);
        #1;
        compareNext();
    endtask

    task automatic pulse(input logic [NP-1:0] v);
        applyStimulus(v, 1'b0);
        applyStimulus('0, 1'b0);
    endtask

    task automatic asyncResetCheck(input logic [NP-1:0] hold_vic);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_led",       bus.LED,       '0);
        checkOutput("rst_game_over", bus.game_over, 1'b0);
        checkOutput("rst_score",     bus.score,     '0);
        checkOutput("rst_point",     bus.point,     '0);
        bus.vic = hold_vic;
        modelReset();
        sb_q.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.vic      = '0;
        bus.new_game = 1'b0;
        modelReset();
        #12;
        checkOutput("init_led",       bus.LED,       '0);
        checkOutput("init_score",     bus.score,     '0);
        checkOutput("init_game_over", bus.game_over, 1'b0);
        checkOutput("init_winner",    bus.winner,    '0);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus('0, 1'b0);

        $display("[TB] single winner and blink");
        pulse(2'b10);
        pulse(2'b10);
        for (int k = 0; k < WP; k++) pulse(2'b01);
        for (int k = 0; k < 12; k++) applyStimulus('0, 1'b0);
        pulse(2'b10);
        applyStimulus(2'b01, 1'b1);
        applyStimulus(2'b01, 1'b0);
        applyStimulus('0, 1'b0);

        $display("[TB] simultaneous tie");
        for (int k = 0; k < WP; k++) pulse(2'b11);
        for (int k = 0; k < 4; k++) applyStimulus('0, 1'b0);
        asyncResetCheck('0);
        applyStimulus('0, 1'b0);

        $display("[TB] held level scores once");
        for (int k = 0; k < 20; k++) applyStimulus(2'b10, 1'b0);
        applyStimulus('0, 1'b0);

        $display("[TB] random traffic");
        for (int k = 0; k < 80; k++) begin
            applyStimulus(NP'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("[TB] reset mid-match with vic held");
        applyStimulus('0, 1'b1);
        applyStimulus('0, 1'b0);
        for (int k = 0; k < 3; k++) pulse(2'b01);
        asyncResetCheck(2'b11);
        for (int k = 0; k < 3; k++) applyStimulus(2'b11, 1'b0);
        applyStimulus('0, 1'b0);
        pulse(2'b01);
        applyStimulus('0, 1'b0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end
endmodule
